seed_extend_xdrop: RTL
======================

Name: seed_extend_xdrop

Overview:
- Ungapped X-drop seed extension engine for the 2-bit nucleotide BLAST pipeline. It is the parametrised successor of the fixed-width exact-match expander.
- Takes one seed hit (query position plus DB beat/offset) and fetches up to three DB beats around the hit through a request/response port.
- Extends left and right in parallel, one base per side per cycle, using match/mismatch scoring with X-drop termination.
- Reports the best-scoring HSP bounds and score through a valid/ready result port.

Parameters:
DB_W, 512, bits per DB beat (DB_W/2 bases per beat, base i at bits [2i+1:2i])
Q_W, 512, query register width (Q_W/2 bases)
SEED_LEN, 11, seed length in bases
MAX_EXT, 100, max extension per side in bases; must be <= DB_W/2
MATCH, 1, signed score per matching base
MISMATCH, -3, signed score per mismatching base
XDROP, 10, extension stops when running score <= best - XDROP
ADDR_W, 32, beat/base address width
SCORE_W, 16, signed score width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  seed valid; accepted only when busy=0
query  in  Q_W  query bases, latched with start
seed_q_pos  in  16  query base index of first seed base
seed_db_beat  in  ADDR_W  DB beat holding first seed base
seed_db_off  in  16  base offset of seed within that beat
db_last_beat  in  ADDR_W  index of final DB beat
busy  out  1  high from accepted start until result handshake
req_valid  out  1  beat fetch request
req_addr  out  ADDR_W  beat index requested
req_ready  in  1  memory accepts request
rsp_valid  in  1  beat data valid
rsp_data  in  DB_W  beat data
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
result_start  out  ADDR_W  absolute DB base address of HSP first base
result_end  out  ADDR_W  absolute DB base address of HSP last base
result_score  out  SCORE_W  signed HSP score

Behaviour:
- Reset: busy, req_valid, result_valid = 0; req_addr, result_start, result_end, result_score = 0; state = IDLE. Reset mid-operation aborts immediately; a stale rsp_valid arriving in IDLE is ignored.
- States: IDLE -> FETCH_P -> FETCH_C -> FETCH_N -> EXTEND -> DONE -> IDLE.
- IDLE, start=1: latch all inputs, set busy. Seed address A = seed_db_beat*(DB_W/2) + seed_db_off. Go to FETCH_P.
- FETCH_P is skipped (prev beat zero-filled) if seed_db_beat==0. FETCH_N is skipped if seed_db_beat==db_last_beat.
- Each fetch state:
  - Hold req_valid with req_addr (beat-1, beat, beat+1) until req_ready.
  - Then deassert req_valid and wait for rsp_valid; store the beat into its 3*DB_W window slot.
  - Only one request is outstanding at a time.
- Window base index of seed W = DB_W/2 + seed_db_off.
- Left limit LL = min(MAX_EXT, seed_q_pos, bases available left of W in fetched beats).
- Right limit RL = min(MAX_EXT, Q_W/2 - seed_q_pos - SEED_LEN, bases available right of seed end in fetched beats).
- Zero-filled beats are never scored.
- The seed is not re-checked; its score is SEED_LEN*MATCH.
- EXTEND: each side keeps a running score, a best score (init 0) and best length (init 0).
  - Per cycle, each still-active side compares the next base (left: W-1-k vs q_pos-1-k; right: W+SEED_LEN+k vs q_pos+SEED_LEN+k).
  - It adds MATCH or MISMATCH. If running > best, it updates best and best length to k+1.
  - A side deactivates when running <= best - XDROP, or when k+1 reaches its limit (LL or RL); a limit of 0 means inactive from the start.
- EXTEND exits when both sides are inactive. It takes max(cycles_L, cycles_R) cycles, minimum 1.
- DONE:
  - result_start = A - bestL_len.
  - result_end = A + SEED_LEN - 1 + bestR_len.
  - result_score = SEED_LEN*MATCH + bestL + bestR.
  - Assert result_valid; hold all result fields stable until result_ready. On handshake, clear result_valid and busy and return to IDLE.
- start while busy=1 is ignored. result_ready while result_valid=0 has no effect.
- Score arithmetic is signed SCORE_W with no saturation. Parameters must guarantee (SEED_LEN+2*MAX_EXT)*|MISMATCH| < 2^(SCORE_W-1).

Test Plan:
- Perfect match, beat=4, off=128, q_pos=120, query equal to DB, zero-wait memory -> req_addr sequence 3,4,5; result_start=1052, result_end=1262, result_score=211.
- Same seed, left side 5 matches then all mismatches, right perfect -> left stops after 4 mismatches; result_start=1147, result_end=1262, score=116.
- beat=0, off=3, q_pos=50, perfect match -> no FETCH_P (requests 0,1 only); LL=3; result_start=0, result_end=113, score=114.
- q_pos=240, perfect match, beat=4, off=128 -> RL=5, LL=100; result_end=1167, score=116.
- Memory stalls: req_ready low 7 cycles, rsp_valid delayed 5 cycles per beat; result_ready held low 10 cycles -> results identical to the first scenario; result fields stable while stalled; start pulses during busy are ignored.
- rst asserted during EXTEND, then a late rsp_valid pulse -> all outputs 0 the next cycle, busy=0, the late rsp is ignored; a new start completes normally.

Source files
------------

// File: rtl/seed_extend_xdrop.sv
`default_nettype none
// ============================================================================
// seed_extend_xdrop : ungapped X-drop seed extension over a 3-beat DB window
// Revision 1.0
// ============================================================================
module seed_extend_xdrop #(
  parameter int DB_W     = 512,
  parameter int Q_W      = 512,
  parameter int SEED_LEN = 11,
  parameter int MAX_EXT  = 100,
  parameter int MATCH    = 1,
  parameter int MISMATCH = -3,
  parameter int XDROP    = 10,
  parameter int ADDR_W   = 32,
  parameter int SCORE_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [Q_W-1:0]            query,
  input  logic [15:0]               seed_q_pos,
  input  logic [ADDR_W-1:0]         seed_db_beat,
  input  logic [15:0]               seed_db_off,
  input  logic [ADDR_W-1:0]         db_last_beat,
  output logic                      busy,
  output logic                      req_valid,
  output logic [ADDR_W-1:0]         req_addr,
  input  logic                      req_ready,
  input  logic                      rsp_valid,
  input  logic [DB_W-1:0]           rsp_data,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [ADDR_W-1:0]         result_start,
  output logic [ADDR_W-1:0]         result_end,
  output logic signed [SCORE_W-1:0] result_score
);

  localparam int BPB      = DB_W / 2;
  localparam int QB       = Q_W / 2;
  localparam int WIN_BITS = 3 * DB_W;
  localparam int WB_W     = $clog2(WIN_BITS);
  localparam int QI_W     = $clog2(Q_W);
  localparam logic signed [SCORE_W-1:0] S_MATCH    = SCORE_W'(MATCH);
  localparam logic signed [SCORE_W-1:0] S_MISMATCH = SCORE_W'(MISMATCH);
  localparam logic signed [SCORE_W-1:0] S_XDROP    = SCORE_W'(XDROP);
  localparam logic signed [SCORE_W-1:0] S_SEED     = SCORE_W'(SEED_LEN * MATCH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_P = 3'd1,
    FETCH_C = 3'd2,
    FETCH_N = 3'd3,
    EXTEND  = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t state, state_nx;

  logic [Q_W-1:0]      q_reg;
  logic [15:0]         q_pos;
  logic [15:0]         off;
  logic [ADDR_W-1:0]   beat;
  logic                have_next;
  logic                req_done;
  logic [WIN_BITS-1:0] win;
  logic [ADDR_W-1:0]   seed_addr;

  logic [15:0]               lim_l, lim_r, k_l, k_r, len_l, len_r;
  logic signed [SCORE_W-1:0] run_l, run_r, best_l, best_r;
  logic                      act_l, act_r;

  function automatic logic [31:0] min3(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c);
    logic [31:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  // Extension limits are fixed by the seed inputs alone, so they are latched with start.
  logic [31:0] in_off, in_qpos, left_avail, seed_end, win_hi, right_avail, right_q;
  logic [31:0] ll_w, rl_w;
  always_comb begin
    in_off      = {16'd0, seed_db_off};
    in_qpos     = {16'd0, seed_q_pos};
    left_avail  = (seed_db_beat != '0) ? 32'(BPB) + in_off : in_off;
    seed_end    = 32'(BPB) + in_off + 32'(SEED_LEN);
    win_hi      = (seed_db_beat != db_last_beat) ? 32'(3 * BPB) : 32'(2 * BPB);
    right_avail = (win_hi > seed_end) ? win_hi - seed_end : 32'd0;
    right_q     = (32'(QB) > in_qpos + 32'(SEED_LEN)) ? 32'(QB) - in_qpos - 32'(SEED_LEN) : 32'd0;
    ll_w        = min3(32'(MAX_EXT), in_qpos, left_avail);
    rl_w        = min3(32'(MAX_EXT), right_q, right_avail);
  end

  logic [WB_W-1:0]           l_wbit, r_wbit;
  logic [QI_W-1:0]           l_qbit, r_qbit;
  logic                      l_hit, r_hit;
  logic signed [SCORE_W-1:0] run_l_nx, best_l_nx, run_r_nx, best_r_nx;
  logic [15:0]               k_l_nx, len_l_nx, k_r_nx, len_r_nx;
  logic                      act_l_nx, act_r_nx;

  always_comb begin
    l_wbit = WB_W'((32'(BPB) + {16'd0, off} - 32'd1 - {16'd0, k_l}) << 1);
    l_qbit = QI_W'(({16'd0, q_pos} - 32'd1 - {16'd0, k_l}) << 1);
    r_wbit = WB_W'((32'(BPB) + {16'd0, off} + 32'(SEED_LEN) + {16'd0, k_r}) << 1);
    r_qbit = QI_W'(({16'd0, q_pos} + 32'(SEED_LEN) + {16'd0, k_r}) << 1);
    l_hit  = (win[l_wbit +: 2] == q_reg[l_qbit +: 2]);
    r_hit  = (win[r_wbit +: 2] == q_reg[r_qbit +: 2]);

    run_l_nx = run_l; best_l_nx = best_l; len_l_nx = len_l; k_l_nx = k_l; act_l_nx = act_l;
    if (state == EXTEND && act_l) begin
      run_l_nx = run_l + (l_hit ? S_MATCH : S_MISMATCH);
      k_l_nx   = k_l + 16'd1;
      if (run_l_nx > best_l) begin
        best_l_nx = run_l_nx;
        len_l_nx  = k_l_nx;
      end
      if ((run_l_nx <= best_l_nx - S_XDROP) || (k_l_nx == lim_l)) act_l_nx = 1'b0;
    end

    run_r_nx = run_r; best_r_nx = best_r; len_r_nx = len_r; k_r_nx = k_r; act_r_nx = act_r;
    if (state == EXTEND && act_r) begin
      run_r_nx = run_r + (r_hit ? S_MATCH : S_MISMATCH);
      k_r_nx   = k_r + 16'd1;
      if (run_r_nx > best_r) begin
        best_r_nx = run_r_nx;
        len_r_nx  = k_r_nx;
      end
      if ((run_r_nx <= best_r_nx - S_XDROP) || (k_r_nx == lim_r)) act_r_nx = 1'b0;
    end
  end

  always_comb begin
    state_nx  = state;
    req_valid = 1'b0;
    req_addr  = '0;
    case (state)
      IDLE: if (start) state_nx = (seed_db_beat != '0) ? FETCH_P : FETCH_C;
      FETCH_P: begin
        req_valid = !req_done;
        req_addr  = beat - ADDR_W'(1);
        if (req_done && rsp_valid) state_nx = FETCH_C;
      end
      FETCH_C: begin
        req_valid = !req_done;
        req_addr  = beat;
        if (req_done && rsp_valid) state_nx = have_next ? FETCH_N : EXTEND;
      end
      FETCH_N: begin
        req_valid = !req_done;
        req_addr  = beat + ADDR_W'(1);
        if (req_done && rsp_valid) state_nx = EXTEND;
      end
      EXTEND: if (!act_l_nx && !act_r_nx) state_nx = DONE;
      DONE:   if (result_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);
  assign seed_addr    = beat * ADDR_W'(BPB) + ADDR_W'(off);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_start <= '0;
      result_end   <= '0;
      result_score <= '0;
      req_done     <= 1'b0;
      act_l        <= 1'b0;
      act_r        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          q_reg     <= query;
          q_pos     <= seed_q_pos;
          off       <= seed_db_off;
          beat      <= seed_db_beat;
          have_next <= (seed_db_beat != db_last_beat);
          win       <= '0;
          req_done  <= 1'b0;
          lim_l     <= ll_w[15:0];
          lim_r     <= rl_w[15:0];
          act_l     <= (ll_w != 32'd0);
          act_r     <= (rl_w != 32'd0);
          k_l <= '0; k_r <= '0; len_l <= '0; len_r <= '0;
          run_l <= '0; run_r <= '0; best_l <= '0; best_r <= '0;
        end
        FETCH_P, FETCH_C, FETCH_N: begin
          if (!req_done) begin
            if (req_ready) req_done <= 1'b1;
          end else if (rsp_valid) begin
            req_done <= 1'b0;
            if (state == FETCH_P)      win[DB_W-1:0]        <= rsp_data;
            else if (state == FETCH_C) win[2*DB_W-1:DB_W]   <= rsp_data;
            else                       win[3*DB_W-1:2*DB_W] <= rsp_data;
          end
        end
        EXTEND: begin
          run_l <= run_l_nx; best_l <= best_l_nx; len_l <= len_l_nx; k_l <= k_l_nx; act_l <= act_l_nx;
          run_r <= run_r_nx; best_r <= best_r_nx; len_r <= len_r_nx; k_r <= k_r_nx; act_r <= act_r_nx;
          if (!act_l_nx && !act_r_nx) begin
            result_start <= seed_addr - ADDR_W'(len_l_nx);
            result_end   <= seed_addr + ADDR_W'(SEED_LEN - 1) + ADDR_W'(len_r_nx);
            result_score <= S_SEED + best_l_nx + best_r_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
